// File: rtl/map_access_arbiter.sv
// map_access_arbiter: three-requester map RAM arbiter with display starvation promotion
module map_access_arbiter #(
  parameter int MAP_DEPTH    = 220,
  parameter int ADDR_W       = 8,
  parameter int CELL_W       = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clock_50,
  input  logic              reset_flag,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              s_gnt,
  output logic              s_valid,
  output logic [CELL_W-1:0] s_rdata,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [CELL_W-1:0] w_wdata,
  output logic              w_gnt,
  output logic              w_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [CELL_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy,
  output logic              addr_err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SRC_W, SRC_S, SRC_D} src_t;
  state_t state, state_n;
  src_t win, win_n;
  logic [CW-1:0] starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [CELL_W-1:0] lat_wdata, s_hold, d_hold, rd_cell;
  logic any_req, in_range, arb;
  // state register; async reset drops any transaction in flight
  always_ff @(posedge clock_50 or posedge reset_flag)
    if (reset_flag) state <= IDLE;
    else state <= state_n;
  // next state, winner selection and all transaction strobes
  always_comb begin
    any_req  = s_req | w_req | d_req;
    arb      = state == IDLE && any_req;
    win_n    = (d_req && starve_cnt >= CW'(STARVE_LIMIT)) ? SRC_D :
               w_req ? SRC_W : s_req ? SRC_S : SRC_D;
    state_n  = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    in_range = lat_addr != '0 && int'(lat_addr) <= MAP_DEPTH;
    rd_cell  = in_range ? mem_rdata : CELL_W'(1);
    busy     = state != IDLE;
    w_gnt    = state == ACCESS && win == SRC_W;
    s_gnt    = state == ACCESS && win == SRC_S;
    d_gnt    = state == ACCESS && win == SRC_D;
    mem_we   = w_gnt && in_range;
    w_done   = state == RESP && win == SRC_W;
    s_valid  = state == RESP && win == SRC_S;
    d_valid  = state == RESP && win == SRC_D;
    addr_err = state == RESP && !in_range;
    s_rdata  = s_valid ? rd_cell : s_hold;
    d_rdata  = d_valid ? rd_cell : d_hold;
    mem_addr = lat_addr;
    mem_wdata = lat_wdata;
  end
  // latch the winner's request at arbitration, track display starvation, hold read data
  always_ff @(posedge clock_50 or posedge reset_flag)
    if (reset_flag) begin
      win        <= SRC_W;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
      s_hold     <= '0;
      d_hold     <= '0;
    end else begin
      if (arb) begin
        win       <= win_n;
        lat_addr  <= win_n == SRC_W ? w_addr : win_n == SRC_S ? s_addr : d_addr;
        lat_wdata <= w_wdata;
      end
      if (state == IDLE)
        starve_cnt <= (d_req && win_n != SRC_D) ?
                      (starve_cnt == CW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
      if (s_valid) s_hold <= rd_cell;
      if (d_valid) d_hold <= rd_cell;
    end
endmodule

// File: tb/tb_map_access_arbiter.sv
// tb_map_access_arbiter: directed checks of arbitration, starvation, range errors and reset
module tb_map_access_arbiter;
  logic clock_50 = 0, reset_flag = 1;
  logic s_req = 0, w_req = 0, d_req = 0;
  logic [7:0] s_addr = 0, w_addr = 0, d_addr = 0, mem_addr;
  logic [2:0] w_wdata = 0, s_rdata, d_rdata, mem_wdata, mem_rdata;
  logic s_gnt, s_valid, w_gnt, w_done, d_gnt, d_valid, mem_we, busy, addr_err;
  logic [2:0] ram [256];
  int total = 0, bad = 0, we_cnt = 0;
  logic [2:0] g;

  map_access_arbiter dut (
    .clock_50(clock_50), .reset_flag(reset_flag),
    .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt), .s_valid(s_valid), .s_rdata(s_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_gnt(w_gnt), .w_done(w_done),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .addr_err(addr_err)
  );

  always #10 clock_50 = ~clock_50;

  // synchronous-read map RAM model
  always @(posedge clock_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_50);
    #1;
  endtask

  task automatic arb3(output logic [2:0] gg);
    tick;
    gg = {w_gnt, s_gnt, d_gnt};
    tick;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 3'b000;
    ram[25] = 3'b111;
    tick;
    check("rst_busy", busy, 0);
    check("rst_strobes", {s_gnt, w_gnt, d_gnt, s_valid, d_valid, w_done, mem_we, addr_err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {s_rdata, d_rdata}, 0);
    tick;
    reset_flag = 0;

    // single read
    s_req = 1; s_addr = 25;
    check("rd_idle_busy", busy, 0);
    tick;
    check("rd_gnt", s_gnt, 1);
    check("rd_busy1", busy, 1);
    check("rd_mem_addr", mem_addr, 25);
    check("rd_we", mem_we, 0);
    tick;
    check("rd_valid", s_valid, 1);
    check("rd_data", s_rdata, 7);
    check("rd_busy2", busy, 1);
    s_req = 0;
    tick;
    check("rd_done_busy", busy, 0);
    check("rd_hold", s_rdata, 7);

    // simultaneous requests: w, s, d grants at cycles 1, 4, 7
    w_req = 1; w_addr = 40; w_wdata = 5;
    s_req = 1; s_addr = 25;
    d_req = 1; d_addr = 40;
    we_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      tick;
      check($sformatf("sim_w_gnt%0d", i), w_gnt, i == 1);
      check($sformatf("sim_s_gnt%0d", i), s_gnt, i == 4);
      check($sformatf("sim_d_gnt%0d", i), d_gnt, i == 7);
      check($sformatf("sim_onehot%0d", i),
            $countones({w_gnt, s_gnt, d_gnt, w_done, s_valid, d_valid}) <= 1, 1);
      if (mem_we) we_cnt++;
      if (w_done) w_req = 0;
      if (s_valid) s_req = 0;
      if (d_valid) begin
        check("sim_d_rdata", d_rdata, 5);
        d_req = 0;
      end
    end
    check("sim_we_once", we_cnt, 1);
    check("sim_ram40", ram[40], 5);

    // starvation: d wins the 17th arbitration, then counter restarts
    w_req = 1; w_addr = 50; w_wdata = 2;
    s_req = 1; s_addr = 25;
    d_req = 1; d_addr = 25;
    for (int k = 1; k <= 18; k++) begin
      arb3(g);
      check($sformatf("starve_arb%0d", k), g, (k == 17) ? 3'b001 : 3'b100);
    end
    check("starve_d_rdata", d_rdata, 7);
    w_req = 0; s_req = 0; d_req = 0;
    tick;

    // out-of-range read then write
    s_req = 1; s_addr = 0;
    tick;
    check("oor_s_gnt", s_gnt, 1);
    check("oor_s_we", mem_we, 0);
    tick;
    check("oor_s_valid", s_valid, 1);
    check("oor_s_rdata", s_rdata, 1);
    check("oor_s_err", addr_err, 1);
    s_req = 0;
    w_req = 1; w_addr = 221; w_wdata = 6;
    tick;
    check("oor_err_low", addr_err, 0);
    tick;
    check("oor_w_gnt", w_gnt, 1);
    check("oor_w_we", mem_we, 0);
    check("oor_w_addr", mem_addr, 221);
    tick;
    check("oor_w_done", w_done, 1);
    check("oor_w_err", addr_err, 1);
    w_req = 0;
    tick;
    check("oor_ram221", ram[221], 0);

    // reset during ACCESS of a write
    w_req = 1; w_addr = 60; w_wdata = 4;
    tick;
    check("rw_we_access", mem_we, 1);
    reset_flag = 1;
    #1;
    check("rw_we_drop", mem_we, 0);
    check("rw_busy_drop", busy, 0);
    check("rw_rdata_clr", {s_rdata, d_rdata}, 0);
    tick;
    check("rw_no_done", w_done, 0);
    check("rw_ram_kept", ram[60], 0);
    reset_flag = 0;
    tick;
    check("rw_regnt", w_gnt, 1);
    check("rw_re_we", mem_we, 1);
    tick;
    check("rw_done", w_done, 1);
    w_req = 0;
    tick;
    check("rw_ram60", ram[60], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/map_access_arbiter.md
MAP_ACCESS_ARBITER -- requirements
Module: map_access_arbiter

Interface
REQ-001 The block SHALL use reset reset_flag, asynchronous, active-high; clock clock_50.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- MAP_DEPTH, 220, number of valid map cells; addresses are 1..MAP_DEPTH.
- ADDR_W, 8, address width.
- CELL_W, 3, cell width.
- STARVE_LIMIT, 16, lost-arbitration count after which the display requester is promoted.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock_50, in, 1, system clock.
- reset_flag, in, 1, async reset.
- s_req, in, 1, sensor read request.
- s_addr, in, ADDR_W, sensor read address.
- s_gnt, out, 1, sensor grant pulse.
- s_valid, out, 1, sensor read-data strobe.
- s_rdata, out, CELL_W, sensor read data.
- w_req, in, 1, trash-removal write request.
- w_addr, in, ADDR_W, write address.
- w_wdata, in, CELL_W, write data.
- w_gnt, out, 1, write grant pulse.
- w_done, out, 1, write complete strobe.
- d_req, in, 1, display-scan read request.
- d_addr, in, ADDR_W, display read address.
- d_gnt, out, 1, display grant pulse.
- d_valid, out, 1, display read-data strobe.
- d_rdata, out, CELL_W, display read data.
- mem_addr, out, ADDR_W, map RAM address.
- mem_we, out, 1, map RAM write enable.
- mem_wdata, out, CELL_W, map RAM write data.
- mem_rdata, in, CELL_W, map RAM read data, valid one cycle after the address.
- busy, out, 1, transaction in flight.
- addr_err, out, 1, one-cycle pulse on an out-of-range access.

Function
REQ-004 Requesters SHALL hold req, addr and wdata stable until their gnt is seen; req may drop only in the cycle after gnt.
REQ-005 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions:
- IDLE to ACCESS when any req=1.
- ACCESS to RESP unconditionally.
- RESP to IDLE unconditionally.
- Throughput is one transaction per 3 cycles maximum.
REQ-006 In IDLE with one or more reqs, the winner SHALL be chosen that cycle and its addr/wdata/type latched.
- Default priority: w > s > d.
- If the starvation counter is at or above STARVE_LIMIT and d_req=1, d wins over all others.
REQ-007 The starvation counter SHALL behave as follows:
- Increments (saturating at STARVE_LIMIT) on each IDLE arbitration where d_req=1 and d loses.
- Clears to 0 when d wins or when d_req=0 in IDLE.
- Width is clog2(STARVE_LIMIT+1).
REQ-008 In ACCESS, the block SHALL drive the memory and grant as follows:
- mem_addr is the latched address.
- mem_we is 1 only for an in-range write; mem_wdata is the latched wdata.
- The winner's gnt is high for exactly this one cycle.
REQ-009 In RESP, the block SHALL complete the transaction as follows:
- For a read, the winner's valid is high for one cycle and its rdata equals mem_rdata.
- For a write, w_done is high for one cycle.
- rdata outputs hold their value until the next valid for the same port.
REQ-010 An address equal to 0 or greater than MAP_DEPTH SHALL be handled as follows:
- mem_we stays 0; mem_addr is still driven.
- gnt is issued normally.
- In RESP a read returns rdata=3'b001 (wall) with valid=1; a write gives w_done=1 with no memory change.
- addr_err pulses in the RESP cycle.
REQ-011 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.
REQ-012 Only one gnt/valid/done SHALL be high in any cycle, and mem_we SHALL never be high outside ACCESS.
REQ-013 A req asserted during ACCESS or RESP SHALL NOT be sampled until the next IDLE cycle, with no lookahead.
REQ-014 If reset_flag asserts mid-transaction, the transaction SHALL be dropped with no valid/done and no further memory write.

Reset
REQ-015 While reset_flag=1, the block SHALL hold:
- state IDLE and starvation counter 0.
- all gnt/valid/done/mem_we/busy/addr_err at 0.
- mem_addr, mem_wdata, s_rdata and d_rdata at 0.
REQ-016 Deassertion of reset_flag SHALL take effect at the next clock_50 rising edge, and the first arbitration SHALL occur in that cycle's IDLE.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Single read: s_req=1, s_addr=25, RAM[25]=3'b111. Required: s_gnt at cycle+1, s_valid with s_rdata=3'b111 at cycle+2, busy high 2 cycles.
- Simultaneous requests: w_req, s_req and d_req all high at the same IDLE. Required: grant order w, s, d at cycles 1, 4, 7; RAM written exactly once.
- Starvation: w_req and s_req held continuously with d_req=1. Required: d wins on the 17th arbitration (counter=16); counter clears afterwards.
- Out-of-range: s_addr=0, then w_addr=221. Required: s_rdata=3'b001 with s_valid; w_done with mem_we never 1; addr_err pulses twice.
- Reset during ACCESS of a write: reset_flag high in the ACCESS cycle. Required: mem_we low immediately, no w_done; after release w_req re-arbitrates and completes.
